store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
- Narrowing counterpart of the load-path sign/zero extenders in the single-cycle datapath.
- Takes a 32-bit register value and a store size (byte/half/word), truncates it to the sub-word, and places it in the correct little-endian lane of the target memory word.
- The data memory has no byte enables, so sub-word stores use a read-modify-write sequence: read the word, merge the lane, write the word back.
- Sits between the EX/MEM store path and the data memory port.

Parameters:
- DATA_W, 32, datapath/memory word width. Only 32 is supported.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit idle; a request is accepted on req_valid && req_ready.
- req_addr  in  ADDR_W  byte address.
- req_data  in  DATA_W  register value; the low bits are used for sub-word stores.
- req_size  in  2  store size: 00 byte, 01 half, 10 word, 11 illegal.
- done  out  1  one-cycle pulse when the store completes.
- err  out  1  one-cycle pulse when a request is misaligned or illegal.
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rdata  in  DATA_W  read data.
- mem_rvalid  in  1  read data valid; latency of 1 or more cycles after mem_rd_en.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wdata  out  DATA_W  write data.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state goes to IDLE.
  - req_ready=1.
  - done, err, mem_rd_en, mem_wr_en=0.
  - mem_addr and mem_wdata=0.
  - Latched request registers are cleared.
  - Reset during any state aborts the operation. No write is issued after reset.
- States: IDLE, RD, WAIT, WR, ERR.
- IDLE: req_ready=1. On accept, latch addr, data and size, then:
  - size 11 → ERR.
  - half with addr[0]=1 → ERR.
  - word with addr[1:0]≠0 → ERR.
  - word, aligned → WR, with merge buffer = req_data.
  - byte or half, aligned → RD.
- RD: mem_rd_en=1 for exactly one cycle, mem_addr=word address → WAIT.
- WAIT: hold until mem_rvalid=1. Then build the merge buffer from mem_rdata:
  - byte: bits [8*a+7:8*a] ← data[7:0], where a=addr[1:0].
  - half: bits [16*h+15:16*h] ← data[15:0], where h=addr[1].
  - All other bits come from mem_rdata unchanged. Upper bits of req_data are discarded.
  - Next state → WR.
- WR: mem_wr_en=1, mem_wdata=merge buffer, mem_addr=word address, and done=1, all in the same cycle → IDLE.
- ERR: err=1 for one cycle, no memory strobes → IDLE.
- req_ready=0 in every state except IDLE. req_valid is ignored while busy.
- mem_rvalid is ignored outside WAIT.
- Latency from the accept edge:
  - Word: write and done in the next cycle (1 cycle).
  - Sub-word: rd_en at +1, earliest rvalid at +2, write at +3, then +N for each extra read-latency cycle.
  - Error: err at +1.
- Back-to-back: a new request can be accepted in the cycle after WR or ERR, which is IDLE. Minimum spacing is 2 cycles.
- mem_wdata and mem_addr hold their last value while no strobe is asserted.

Optional Feature:
- Macro: STORE_MERGE_BYTEEN_EN.
- Defined:
  - Adds output mem_be (4 bits, reset 0000).
  - Sub-word stores skip RD and WAIT and go directly IDLE → WR.
  - mem_wdata carries the value replicated across lanes: byte {4{d[7:0]}}, half {2{d[15:0]}}.
  - mem_be: byte = 1<<a; half = 0011 or 1100 selected by h; word = 1111.
  - mem_rd_en is never asserted.
  - All sizes complete at +1.
- Undefined: mem_be port is absent and read-modify-write is used as described above.

Test Plan:
- Word store, addr=0x100, data=0xDEADBEEF → at +1: mem_wr_en=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, done=1; mem_rd_en never asserted.
- Byte store, addr=0x203, data=0xFFFFFFA5, memory word=0x11223344, rvalid at +2 → rd_en at +1 (addr 0x200); write at +3 with mem_wdata=0xA5223344 and done=1.
- Half store, addr=0x302, data=0x0000BEEF, memory word=0x11223344, rvalid delayed to +5 → req_ready=0 throughout; write at +6 with mem_wdata=0xBEEF3344.
- Misaligned requests: half at 0x401, word at 0x402, size 11 at 0x400 → each gives err=1 at +1, with no rd_en or wr_en.
- Reset mid-operation: assert rst_n=0 during WAIT of a byte store → outputs go to zero immediately; no write ever occurs; req_ready=1 after release; the next word store completes normally.
- With STORE_MERGE_BYTEEN_EN defined: byte store at 0x202 with data 0x5A → at +1: mem_be=0100, mem_wdata=0x5A5A5A5A, done=1; no read is issued.

Source files
------------

// File: rtl/store_merge_unit.sv
// store_merge_unit: narrows a register value to byte/half/word and writes it
// into the correct little-endian lane of a memory word. The default build
// reads the target word, merges the lane and writes the whole word back.
// Optional build macro STORE_MERGE_BYTEEN_EN adds a byte-enable output
// (mem_be), replicates the store data across lanes and writes without the
// read, so every size completes one cycle after it is accepted.
module store_merge_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr_en,
`ifdef STORE_MERGE_BYTEEN_EN
  output logic [3:0]        mem_be,
`endif
  output logic [DATA_W-1:0] mem_wdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_ERR} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   bad_req;

  assign accept = req_valid && (state == S_IDLE);

`ifdef STORE_MERGE_BYTEEN_EN
  // Read port is not used when the memory accepts byte enables.
  logic unused_rd;
  assign unused_rd = mem_rvalid ^ (^mem_rdata);

  function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] size);
    case (size)
      SZ_BYTE: replicate = {4{d[7:0]}};
      SZ_HALF: replicate = {2{d[15:0]}};
      default: replicate = d;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size,
                                         input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << lane;
      SZ_HALF: lane_be = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction
`else
  // Only the low half of the register value and the lane select are kept;
  // the word address already lives in mem_addr.
  logic [15:0] data_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;

  function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] word,
                                                   input logic [15:0] d,
                                                   input logic [1:0] size,
                                                   input logic [1:0] lane);
    logic [DATA_W-1:0] r;
    r = word;
    if (size == SZ_HALF) r[{lane[1], 4'b0000} +: 16] = d;
    else                 r[{lane, 3'b000} +: 8]      = d[7:0];
    return r;
  endfunction
`endif

  // Classify the incoming request as illegal size or misaligned.
  always_comb begin
    bad_req = 1'b0;
    case (req_size)
      SZ_HALF: bad_req = req_addr[0];
      SZ_WORD: bad_req = |req_addr[1:0];
      SZ_BYTE: bad_req = 1'b0;
      default: bad_req = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and strobes; every strobe is a single-state decode.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad_req)                 state_nxt = S_ERR;
`ifdef STORE_MERGE_BYTEEN_EN
          else                         state_nxt = S_WR;
`else
          else if (req_size == SZ_WORD) state_nxt = S_WR;
          else                         state_nxt = S_RD;
`endif
        end
      end
      S_RD: begin
        mem_rd_en = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) state_nxt = S_WR;
      end
      S_WR: begin
        mem_wr_en = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, word address and merge buffer; address and write data
  // only change on a legal accept or a merge, so they hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef STORE_MERGE_BYTEEN_EN
      mem_be    <= 4'b0000;
`else
      data_q    <= '0;
      lane_q    <= '0;
      size_q    <= '0;
`endif
    end else begin
      if (accept) begin
`ifndef STORE_MERGE_BYTEEN_EN
        data_q <= req_data[15:0];
        lane_q <= req_addr[1:0];
        size_q <= req_size;
`endif
        if (!bad_req) begin
          mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
`ifdef STORE_MERGE_BYTEEN_EN
          mem_wdata <= replicate(req_data, req_size);
          mem_be    <= lane_be(req_size, req_addr[1:0]);
`else
          if (req_size == SZ_WORD) mem_wdata <= req_data;
`endif
        end
      end
`ifndef STORE_MERGE_BYTEEN_EN
      if (state == S_WAIT && mem_rvalid)
        mem_wdata <= merge_lane(mem_rdata, data_q, size_q, lane_q);
`endif
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed-vector bench for store_merge_unit with
// hand-computed expected values. Honours STORE_MERGE_BYTEEN_EN.
module tb_store_merge_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
`ifdef STORE_MERGE_BYTEEN_EN
  logic [3:0]  mem_be;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  store_merge_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_size   (req_size),
    .done       (done),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wr_en  (mem_wr_en),
`ifdef STORE_MERGE_BYTEEN_EN
    .mem_be     (mem_be),
`endif
    .mem_wdata  (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (the accept edge), then drop valid.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_size   = 2'b00;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_rd", mem_rd_en, 1'b0);
    chk1("rst_wr", mem_wr_en, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
`ifdef STORE_MERGE_BYTEEN_EN
    chk("rst_be", {28'h0, mem_be}, 32'h0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // Word store: write and done one cycle after accept.
    chk1("w_ready_idle", req_ready, 1'b1);
    issue(32'h100, 32'hDEADBEEF, 2'b10);
    chk1("w_wr", mem_wr_en, 1'b1);
    chk1("w_done", done, 1'b1);
    chk1("w_rd", mem_rd_en, 1'b0);
    chk1("w_ready_busy", req_ready, 1'b0);
    chk("w_addr", mem_addr, 32'h100);
    chk("w_wdata", mem_wdata, 32'hDEADBEEF);
`ifdef STORE_MERGE_BYTEEN_EN
    chk("w_be", {28'h0, mem_be}, 32'hF);
`endif
    tick();
    chk1("w_wr_after", mem_wr_en, 1'b0);
    chk1("w_done_after", done, 1'b0);
    chk1("w_ready_after", req_ready, 1'b1);
    chk("w_wdata_hold", mem_wdata, 32'hDEADBEEF);

`ifdef STORE_MERGE_BYTEEN_EN
    // Byte store with byte enables: no read, replicated data.
    issue(32'h202, 32'h0000005A, 2'b00);
    chk1("be_b_wr", mem_wr_en, 1'b1);
    chk1("be_b_done", done, 1'b1);
    chk1("be_b_rd", mem_rd_en, 1'b0);
    chk("be_b_addr", mem_addr, 32'h200);
    chk("be_b_wdata", mem_wdata, 32'h5A5A5A5A);
    chk("be_b_be", {28'h0, mem_be}, 32'h4);
    tick();
    // Half store, upper lane.
    issue(32'h302, 32'h1234BEEF, 2'b01);
    chk1("be_h_wr", mem_wr_en, 1'b1);
    chk1("be_h_rd", mem_rd_en, 1'b0);
    chk("be_h_wdata", mem_wdata, 32'hBEEFBEEF);
    chk("be_h_be", {28'h0, mem_be}, 32'hC);
    tick();
`else
    // Byte store, lane 3, read data returned at +2.
    issue(32'h203, 32'hFFFFFFA5, 2'b00);
    chk1("b_rd", mem_rd_en, 1'b1);
    chk1("b_wr_p1", mem_wr_en, 1'b0);
    chk1("b_ready_p1", req_ready, 1'b0);
    chk("b_addr_rd", mem_addr, 32'h200);
    // rvalid while in the read-strobe cycle must be ignored.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    tick();
    chk1("b_rd_p2", mem_rd_en, 1'b0);
    chk1("b_wr_p2", mem_wr_en, 1'b0);
    chk1("b_ready_p2", req_ready, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11223344;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    chk1("b_wr", mem_wr_en, 1'b1);
    chk1("b_done", done, 1'b1);
    chk("b_addr_wr", mem_addr, 32'h200);
    chk("b_wdata", mem_wdata, 32'hA5223344);
    tick();
    chk1("b_ready_after", req_ready, 1'b1);

    // Half store, upper half, read data delayed to +5.
    issue(32'h302, 32'h0000BEEF, 2'b01);
    chk1("h_rd", mem_rd_en, 1'b1);
    chk("h_addr_rd", mem_addr, 32'h300);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk1("h_ready_wait", req_ready, 1'b0);
      chk1("h_wr_wait", mem_wr_en, 1'b0);
      chk1("h_rd_wait", mem_rd_en, 1'b0);
    end
    tick();
    chk1("h_ready_p5", req_ready, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11223344;
    tick();
    mem_rvalid = 1'b0;
    chk1("h_wr", mem_wr_en, 1'b1);
    chk1("h_done", done, 1'b1);
    chk("h_wdata", mem_wdata, 32'hBEEF3344);
    tick();
`endif

    // Illegal / misaligned requests, issued back-to-back.
    begin
      logic [31:0] ea [3];
      logic [1:0]  es [3];
      ea[0] = 32'h401; es[0] = 2'b01;
      ea[1] = 32'h402; es[1] = 2'b10;
      ea[2] = 32'h400; es[2] = 2'b11;
      for (int i = 0; i < 3; i++) begin
        issue(ea[i], 32'hCAFEF00D, es[i]);
        chk1("e_err", err, 1'b1);
        chk1("e_rd", mem_rd_en, 1'b0);
        chk1("e_wr", mem_wr_en, 1'b0);
        chk1("e_done", done, 1'b0);
        chk("e_addr_hold", mem_addr, 32'h300);
        tick();
        chk1("e_err_after", err, 1'b0);
        chk1("e_ready_after", req_ready, 1'b1);
      end
    end

`ifndef STORE_MERGE_BYTEEN_EN
    // Reset in the middle of a byte store's read wait.
    issue(32'h203, 32'h000000A5, 2'b00);
    tick();
    chk1("r_in_wait_ready", req_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("r_ready", req_ready, 1'b1);
    chk1("r_wr", mem_wr_en, 1'b0);
    chk1("r_rd", mem_rd_en, 1'b0);
    chk("r_addr", mem_addr, 32'h0);
    chk("r_wdata", mem_wdata, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11223344;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk1("r_no_write", mem_wr_en, 1'b0);
      tick();
    end
    mem_rvalid = 1'b0;
    chk1("r_ready_rel", req_ready, 1'b1);
    issue(32'h104, 32'h12345678, 2'b10);
    chk1("r_w_wr", mem_wr_en, 1'b1);
    chk("r_w_addr", mem_addr, 32'h104);
    chk("r_w_wdata", mem_wdata, 32'h12345678);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
